// File: rtl/innings_score_keeper.sv
// innings_score_keeper
//   Ball-by-ball scoring engine for a two-innings T20 match. It accepts one
//   delivery event per valid/ready handshake, accumulates runs, wickets and
//   legal balls for the batting side, and sequences
//   IDLE -> INN1 -> BREAK -> INN2 -> DONE.
//
// Ports
//   clk_fpga       : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   start          : pulse; begins innings 1 from IDLE, innings 2 from BREAK
//   evt_valid      : delivery event present
//   evt_ready      : event can be accepted (INN1/INN2 only, combinational)
//   evt_runs       : runs on the delivery, 0-6 (7 is read as 6)
//   evt_extra      : wide/no-ball; +1 penalty run, ball not counted
//   evt_wicket     : dismissal on this delivery
//   team1Data      : {runs[7:0], wickets[3:0]} of team 1
//   team2Data      : {runs[7:0], wickets[3:0]} of team 2
//   team1Balls     : legal balls faced by team 1
//   team2Balls     : legal balls faced by team 2
//   binarywickets  : wickets in the current innings
//   balls          : legal balls in the current innings, zero-extended
//   over_num       : completed overs in the current innings
//   ball_in_over   : legal balls in the current over (0-5)
//   batting_team   : 0 = team 1, 1 = team 2
//   innings_end    : one-cycle pulse after the closing delivery
//   match_done     : high once the second innings has closed
module innings_score_keeper #(
  parameter int MAX_BALLS = 120,
  parameter int MAX_WKTS  = 10,
  parameter int RUN_SAT   = 255
) (
  input  logic        clk_fpga,
  input  logic        reset_n,
  input  logic        start,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic [2:0]  evt_runs,
  input  logic        evt_extra,
  input  logic        evt_wicket,
  output logic [11:0] team1Data,
  output logic [11:0] team2Data,
  output logic [6:0]  team1Balls,
  output logic [6:0]  team2Balls,
  output logic [3:0]  binarywickets,
  output logic [15:0] balls,
  output logic [4:0]  over_num,
  output logic [2:0]  ball_in_over,
  output logic        batting_team,
  output logic        innings_end,
  output logic        match_done
);

  localparam logic [6:0] MAX_BALLS_C = 7'(MAX_BALLS);
  localparam logic [3:0] MAX_WKTS_C  = 4'(MAX_WKTS);
  localparam logic [8:0] RUN_SAT_C   = 9'(RUN_SAT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INN1  = 3'd1,
    BREAK = 3'd2,
    INN2  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] t1_runs_q, t1_runs_d, t2_runs_q, t2_runs_d;
  logic [3:0] t1_wkts_q, t1_wkts_d, t2_wkts_q, t2_wkts_d;
  logic [6:0] t1_balls_q, t1_balls_d, t2_balls_q, t2_balls_d;
  logic [3:0] cur_wkts_q, cur_wkts_d;
  logic [6:0] cur_balls_q, cur_balls_d;
  logic [4:0] over_q, over_d;
  logic [2:0] bio_q, bio_d;
  logic       bat_q, bat_d;
  logic       end_q, end_d;
  logic       done_q, done_d;

  // Post-update values of the batting side for the event on the inputs
  logic       accept;
  logic [2:0] eff_runs;
  logic [7:0] bat_runs;
  logic [8:0] run_sum;
  logic [7:0] runs_new;
  logic [3:0] wkts_new;
  logic [6:0] balls_new;
  logic [4:0] over_new;
  logic [2:0] bio_new;
  logic       close;

  assign evt_ready = (state_q == INN1) || (state_q == INN2);
  assign accept    = evt_valid && evt_ready;

  always_comb begin
    eff_runs  = (evt_runs == 3'd7) ? 3'd6 : evt_runs;
    bat_runs  = bat_q ? t2_runs_q : t1_runs_q;
    // 9-bit sum so a carry out of the 8-bit field is seen and clamped
    run_sum   = {1'b0, bat_runs} + {6'd0, eff_runs} + {8'd0, evt_extra};
    runs_new  = (run_sum > RUN_SAT_C) ? RUN_SAT_C[7:0] : run_sum[7:0];
    wkts_new  = (evt_wicket && (cur_wkts_q < MAX_WKTS_C)) ? cur_wkts_q + 4'd1 : cur_wkts_q;
    balls_new = cur_balls_q;
    over_new  = over_q;
    bio_new   = bio_q;
    if (!evt_extra) begin
      balls_new = cur_balls_q + 7'd1;
      if (bio_q == 3'd5) begin
        bio_new  = 3'd0;
        over_new = over_q + 5'd1;
      end else begin
        bio_new  = bio_q + 3'd1;
      end
    end
    close = (wkts_new == MAX_WKTS_C) || (balls_new == MAX_BALLS_C);
  end

  always_comb begin
    state_d     = state_q;
    t1_runs_d   = t1_runs_q;
    t1_wkts_d   = t1_wkts_q;
    t1_balls_d  = t1_balls_q;
    t2_runs_d   = t2_runs_q;
    t2_wkts_d   = t2_wkts_q;
    t2_balls_d  = t2_balls_q;
    cur_wkts_d  = cur_wkts_q;
    cur_balls_d = cur_balls_q;
    over_d      = over_q;
    bio_d       = bio_q;
    bat_d       = bat_q;
    end_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INN1;
          bat_d   = 1'b0;
        end
      end
      BREAK: begin
        // Current-innings mirrors hold team 1 figures until innings 2 starts
        if (start) begin
          state_d     = INN2;
          bat_d       = 1'b1;
          cur_wkts_d  = 4'd0;
          cur_balls_d = 7'd0;
          over_d      = 5'd0;
          bio_d       = 3'd0;
        end
      end
      INN1, INN2: begin
        if (accept) begin
          cur_wkts_d  = wkts_new;
          cur_balls_d = balls_new;
          over_d      = over_new;
          bio_d       = bio_new;
          if (bat_q) begin
            t2_runs_d  = runs_new;
            t2_wkts_d  = wkts_new;
            t2_balls_d = balls_new;
          end else begin
            t1_runs_d  = runs_new;
            t1_wkts_d  = wkts_new;
            t1_balls_d = balls_new;
          end
          if (close) begin
            state_d = (state_q == INN1) ? BREAK : DONE;
            end_d   = 1'b1;
          end
        end
      end
      default: state_d = state_q;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      t1_runs_q   <= 8'd0;
      t1_wkts_q   <= 4'd0;
      t1_balls_q  <= 7'd0;
      t2_runs_q   <= 8'd0;
      t2_wkts_q   <= 4'd0;
      t2_balls_q  <= 7'd0;
      cur_wkts_q  <= 4'd0;
      cur_balls_q <= 7'd0;
      over_q      <= 5'd0;
      bio_q       <= 3'd0;
      bat_q       <= 1'b0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t1_runs_q   <= t1_runs_d;
      t1_wkts_q   <= t1_wkts_d;
      t1_balls_q  <= t1_balls_d;
      t2_runs_q   <= t2_runs_d;
      t2_wkts_q   <= t2_wkts_d;
      t2_balls_q  <= t2_balls_d;
      cur_wkts_q  <= cur_wkts_d;
      cur_balls_q <= cur_balls_d;
      over_q      <= over_d;
      bio_q       <= bio_d;
      bat_q       <= bat_d;
      end_q       <= end_d;
      done_q      <= done_d;
    end
  end

  assign team1Data     = {t1_runs_q, t1_wkts_q};
  assign team2Data     = {t2_runs_q, t2_wkts_q};
  assign team1Balls    = t1_balls_q;
  assign team2Balls    = t2_balls_q;
  assign binarywickets = cur_wkts_q;
  assign balls         = {9'd0, cur_balls_q};
  assign over_num      = over_q;
  assign ball_in_over  = bio_q;
  assign batting_team  = bat_q;
  assign innings_end   = end_q;
  assign match_done    = done_q;

endmodule

// File: tb/tb_innings_score_keeper.sv
module tb_innings_score_keeper;

  logic        clk_fpga = 1'b0;
  logic        reset_n;
  logic        start;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_runs;
  logic        evt_extra;
  logic        evt_wicket;
  logic [11:0] team1Data;
  logic [11:0] team2Data;
  logic [6:0]  team1Balls;
  logic [6:0]  team2Balls;
  logic [3:0]  binarywickets;
  logic [15:0] balls;
  logic [4:0]  over_num;
  logic [2:0]  ball_in_over;
  logic        batting_team;
  logic        innings_end;
  logic        match_done;

  innings_score_keeper dut (
    .clk_fpga      (clk_fpga),
    .reset_n       (reset_n),
    .start         (start),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_runs      (evt_runs),
    .evt_extra     (evt_extra),
    .evt_wicket    (evt_wicket),
    .team1Data     (team1Data),
    .team2Data     (team2Data),
    .team1Balls    (team1Balls),
    .team2Balls    (team2Balls),
    .binarywickets (binarywickets),
    .balls         (balls),
    .over_num      (over_num),
    .ball_in_over  (ball_in_over),
    .batting_team  (batting_team),
    .innings_end   (innings_end),
    .match_done    (match_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  int passed = 0;
  int total  = 0;

  // Reference model: match phase (0 idle, 1 inn1, 2 break, 3 inn2, 4 done)
  // and per-team totals; overs are derived from the ball count.
  int m_phase;
  int m_bat;
  int m_runs [2];
  int m_wkts [2];
  int m_balls[2];
  int m_end;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_bat   = 0;
    m_end   = 0;
    for (int t = 0; t < 2; t++) begin
      m_runs[t]  = 0;
      m_wkts[t]  = 0;
      m_balls[t] = 0;
    end
  endtask

  task automatic model_step(input logic st, input logic v, input logic [2:0] r,
                            input logic ex, input logic wk);
    int add;
    m_end = 0;
    if (st && m_phase == 0) begin
      m_phase = 1;
      m_bat   = 0;
    end else if (st && m_phase == 2) begin
      m_phase = 3;
      m_bat   = 1;
    end else if (v && (m_phase == 1 || m_phase == 3)) begin
      add = ((r > 6) ? 6 : int'(r)) + int'(ex);
      m_runs[m_bat] = (m_runs[m_bat] + add > 255) ? 255 : m_runs[m_bat] + add;
      if (wk && m_wkts[m_bat] < 10) m_wkts[m_bat]++;
      if (!ex) m_balls[m_bat]++;
      if (m_wkts[m_bat] == 10 || m_balls[m_bat] == 120) begin
        m_phase++;
        m_end = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0]  r0, r1;
    logic [3:0]  w0, w1, wc;
    r0 = 8'(m_runs[0]);
    r1 = 8'(m_runs[1]);
    w0 = 4'(m_wkts[0]);
    w1 = 4'(m_wkts[1]);
    wc = 4'(m_wkts[m_bat]);
    chk({tag, ".evt_ready"},     16'(evt_ready),     16'(m_phase == 1 || m_phase == 3));
    chk({tag, ".team1Data"},     16'(team1Data),     16'({r0, w0}));
    chk({tag, ".team2Data"},     16'(team2Data),     16'({r1, w1}));
    chk({tag, ".team1Balls"},    16'(team1Balls),    16'(m_balls[0]));
    chk({tag, ".team2Balls"},    16'(team2Balls),    16'(m_balls[1]));
    chk({tag, ".binarywickets"}, 16'(binarywickets), 16'(wc));
    chk({tag, ".balls"},         balls,              16'(m_balls[m_bat]));
    chk({tag, ".over_num"},      16'(over_num),      16'(m_balls[m_bat] / 6));
    chk({tag, ".ball_in_over"},  16'(ball_in_over),  16'(m_balls[m_bat] % 6));
    chk({tag, ".batting_team"},  16'(batting_team),  16'(m_bat));
    chk({tag, ".innings_end"},   16'(innings_end),   16'(m_end));
    chk({tag, ".match_done"},    16'(match_done),    16'(m_phase == 4));
  endtask

  task automatic step(input string tag, input logic st, input logic v, input logic [2:0] r,
                      input logic ex, input logic wk);
    @(negedge clk_fpga);
    start      = st;
    evt_valid  = v;
    evt_runs   = r;
    evt_extra  = ex;
    evt_wicket = wk;
    @(posedge clk_fpga);
    model_step(st, v, r, ex, wk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_fpga);
    reset_n    = 1'b0;
    start      = 1'b0;
    evt_valid  = 1'b0;
    evt_runs   = 3'd0;
    evt_extra  = 1'b0;
    evt_wicket = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk_fpga);
    reset_n = 1'b1;
  endtask

  task automatic random_until(input string tag, input int target);
    int n;
    n = 0;
    while (m_phase < target && n < 1000) begin
      step(tag, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
           3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0));
      n++;
    end
    chk({tag, ".reached_close"}, 16'(m_phase >= target), 16'd1);
  endtask

  initial begin
    reset_n = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Event in IDLE is dropped; event with start is also dropped
    step("idle_evt", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    step("start_evt", 1'b1, 1'b1, 3'd4, 1'b0, 1'b1);

    // 120 dot balls close innings 1 on balls
    for (int i = 0; i < 120; i++) step("dots", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("dots.t1balls_120", 16'(team1Balls), 16'd120);
    chk("dots.over_20", 16'(over_num), 16'd20);
    chk("dots.end_pulse", 16'(innings_end), 16'd1);
    step("ball121", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("ball121.no_pulse", 16'(innings_end), 16'd0);

    // Six fours then ten wickets on legal balls
    do_reset();
    step("st_b", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("fours", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("wkts", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("wkts.team1Data", 16'(team1Data), 16'({8'd24, 4'd10}));
    chk("wkts.team1Balls", 16'(team1Balls), 16'd16);

    // Wides then a legal six; no-ball with wicket
    do_reset();
    step("st_c", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("wides", 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    step("six", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("six.runs_11", 16'(team1Data[11:4]), 16'd11);
    step("nb_wkt", 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    chk("nb_wkt.team1Data", 16'(team1Data), 16'({8'd14, 4'd1}));
    chk("nb_wkt.balls", balls, 16'd1);

    // Saturation
    do_reset();
    step("st_d", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step("sixes", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("sat.runs_255", 16'(team1Data[11:4]), 16'd255);
    chk("sat.balls_50", balls, 16'd50);

    // Directed full match: 150/10 then 140 in 120 balls
    do_reset();
    step("st_e1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step("m1_six", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("m1_wkt", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    step("brk_idle", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    step("st_e2", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) step("m2_four", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 85; i++) step("m2_dot", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("match.t2runs_140", 16'(team2Data[11:4]), 16'd140);
    chk("match.t2balls_120", 16'(team2Balls), 16'd120);
    chk("match.done", 16'(match_done), 16'd1);
    chk("match.t1frozen", 16'(team1Data), 16'({8'd150, 4'd10}));
    step("done_hold", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);

    // Randomized full matches
    for (int k = 0; k < 3; k++) begin
      do_reset();
      random_until("rnd_inn1", 2);
      step("rnd_brk", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
      step("rnd_st2", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      random_until("rnd_inn2", 4);
    end

    // Asynchronous reset in the middle of innings 2
    do_reset();
    step("st_f1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("f_wkt", 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    step("st_f2", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("f_inn2", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    @(negedge clk_fpga);
    evt_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk_fpga);
    reset_n = 1'b1;
    step("post_rst", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
